// File: rtl/sprite_line_gen.sv
// Per-line sprite pixel generator: double-buffered texel row, fractional horizontal
// scaling and mirroring, producing a registered palette index and opaque flag per pixel.
module sprite_line_gen #(
    parameter int BPP   = 2,
    parameter int SPR_W = 16,
    parameter int POS_W = 9,
    parameter int SCL_W = 4,
    parameter int FRAC  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_line_start,
    input  logic [POS_W-1:0]     i_pix_x,
    input  logic [POS_W-1:0]     i_pos_x,
    input  logic [SCL_W-1:0]     i_scale,
    input  logic                 i_mirror,
    input  logic                 i_enable,
    input  logic [BPP*SPR_W-1:0] i_row_data,
    input  logic                 i_row_valid,
    output logic                 o_row_ready,
    output logic [BPP-1:0]       o_col,
    output logic                 o_col_valid,
    output logic                 o_busy
);

    localparam int IDX_W = $clog2(SPR_W);
    localparam int ACC_W = IDX_W + FRAC + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAW, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [BPP*SPR_W-1:0]   r_shadow;
    logic [BPP*SPR_W-1:0]   r_active;
    logic                   r_shadow_full;
    logic [ACC_W-1:0]       r_acc;
    logic [ACC_W-1:0]       r_step;
    logic                   r_mirror;
    logic [POS_W-1:0]       r_pos_x;
    logic [BPP-1:0]         r_col;
    logic                   r_col_valid;

    logic [SCL_W-1:0]       w_step_raw;
    logic [ACC_W-1:0]       w_step;
    logic                   w_load;
    logic                   w_row_avail;
    logic                   w_start_ok;
    logic                   w_hit;
    logic                   w_draw;
    logic [IDX_W:0]         w_idx;
    logic                   w_in_row;
    logic [IDX_W-1:0]       w_sel;
    logic [BPP-1:0]         w_texel;

    assign w_step_raw  = ~i_scale;
    assign w_step      = ACC_W'(w_step_raw);
    assign w_load      = i_row_valid & ~r_shadow_full;
    assign w_row_avail = r_shadow_full | i_row_valid;
    assign w_start_ok  = i_enable & w_row_avail & (w_step != '0);
    assign w_hit       = (r_state == S_WAIT) && (i_pix_x == r_pos_x);

    // The accumulator never exceeds 2*SPR_W texels, so the idx MSB alone flags "past the row".
    assign w_idx    = r_acc[ACC_W-1:FRAC];
    assign w_in_row = ~w_idx[IDX_W];
    assign w_sel    = r_mirror ? w_idx[IDX_W-1:0] : ~w_idx[IDX_W-1:0];
    assign w_texel  = r_active[BPP*w_sel +: BPP];

    always_comb begin
        w_state_nxt = r_state;
        w_draw      = 1'b0;
        if (i_line_start) begin
            w_state_nxt = w_start_ok ? S_WAIT : S_IDLE;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_hit) begin
                        w_state_nxt = S_DRAW;
                        w_draw      = 1'b1;
                    end
                end
                S_DRAW: begin
                    if (w_in_row) w_draw = 1'b1;
                    else          w_state_nxt = S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Row buffering: a line_start swap takes precedence over a shadow load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow      <= '0;
            r_active      <= '0;
            r_shadow_full <= 1'b0;
        end else if (i_line_start) begin
            if (r_shadow_full) begin
                r_active      <= r_shadow;
                r_shadow_full <= 1'b0;
            end else if (i_row_valid) begin
                r_active <= i_row_data;
            end
        end else if (w_load) begin
            r_shadow      <= i_row_data;
            r_shadow_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_step   <= '0;
            r_mirror <= 1'b0;
            r_pos_x  <= '0;
        end else if (i_line_start) begin
            r_acc    <= '0;
            r_step   <= w_step;
            r_mirror <= i_mirror;
            r_pos_x  <= i_pos_x;
        end else if (w_hit) begin
            r_acc <= r_step;
        end else if (r_state == S_DRAW && w_in_row) begin
            r_acc <= r_acc + r_step;
        end
    end

    // Output stage: one cycle behind the pixel it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_col_valid <= 1'b0;
        end else begin
            r_col       <= w_draw ? w_texel : '0;
            r_col_valid <= w_draw && (w_texel != '0);
        end
    end

    assign o_row_ready = ~r_shadow_full;
    assign o_col       = r_col;
    assign o_col_valid = r_col_valid;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sprite_line_gen.sv
// Directed bench for sprite_line_gen: vector table of whole-line sweeps plus
// hand-written reset, buffering, direct-load, fast-step and abort sequences.
module tb_sprite_line_gen;

    localparam int BPP   = 2;
    localparam int SPR_W = 16;
    localparam int POS_W = 9;
    localparam int SCL_W = 4;
    localparam int FRAC  = 3;
    localparam int NPIX  = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 line_start = 1'b0;
    logic [POS_W-1:0]     pix_x = '0;
    logic [POS_W-1:0]     pos_x = '0;
    logic [SCL_W-1:0]     scale = '0;
    logic                 mirror = 1'b0;
    logic                 enable = 1'b0;
    logic [BPP*SPR_W-1:0] row_data = '0;
    logic                 row_valid = 1'b0;
    logic                 row_ready;
    logic [BPP-1:0]       col;
    logic                 col_valid;
    logic                 busy;

    int checks = 0;
    int failures = 0;
    logic [2:0] cap [NPIX];

    sprite_line_gen #(.BPP(BPP), .SPR_W(SPR_W), .POS_W(POS_W), .SCL_W(SCL_W), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .i_line_start(line_start), .i_pix_x(pix_x), .i_pos_x(pos_x),
        .i_scale(scale), .i_mirror(mirror), .i_enable(enable), .i_row_data(row_data),
        .i_row_valid(row_valid), .o_row_ready(row_ready), .o_col(col), .o_col_valid(col_valid),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] row;
        logic [3:0]  scl;
        logic        mir;
        logic        en;
        int          pos;
        int          n;
        int          hold;
        logic [7:0]  pat;   // four 2-bit colours, leftmost is texel group 0
        logic        bsy;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_row(input logic [31:0] d);
        row_data  = d;
        row_valid = 1'b1;
        tick();
        row_valid = 1'b0;
    endtask

    task automatic start_line(input logic [3:0] s, input logic m, input int p, input logic e);
        scale      = s;
        mirror     = m;
        pos_x      = POS_W'(p);
        enable     = e;
        pix_x      = '1;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic sweep(input int load_at, input logic [31:0] ld);
        for (int p = 0; p < NPIX; p++) begin
            pix_x = POS_W'(p);
            if (p == load_at) begin
                row_data  = ld;
                row_valid = 1'b1;
            end
            tick();
            row_valid = 1'b0;
            cap[p] = {col_valid, col};
        end
    endtask

    initial begin
        vecs[0] = '{row: 32'hE4E4_E4E4, scl: 4'd7,  mir: 1'b0, en: 1'b1, pos: 20, n: 16, hold: 1, pat: 8'b11_10_01_00, bsy: 1'b1};
        vecs[1] = '{row: 32'hE4E4_E4E4, scl: 4'd7,  mir: 1'b1, en: 1'b1, pos: 20, n: 16, hold: 1, pat: 8'b00_01_10_11, bsy: 1'b1};
        vecs[2] = '{row: 32'hE4E4_E4E4, scl: 4'd11, mir: 1'b0, en: 1'b1, pos: 20, n: 32, hold: 2, pat: 8'b11_10_01_00, bsy: 1'b1};
        vecs[3] = '{row: 32'hE4E4_E4E4, scl: 4'd15, mir: 1'b0, en: 1'b1, pos: 20, n: 0,  hold: 1, pat: 8'b00_00_00_00, bsy: 1'b0};
        vecs[4] = '{row: 32'hE4E4_E4E4, scl: 4'd7,  mir: 1'b0, en: 1'b0, pos: 20, n: 0,  hold: 1, pat: 8'b00_00_00_00, bsy: 1'b0};
        vecs[5] = '{row: 32'h6C6C_6C6C, scl: 4'd7,  mir: 1'b1, en: 1'b1, pos: 0,  n: 16, hold: 1, pat: 8'b00_11_10_01, bsy: 1'b1};
        vecs[6] = '{row: 32'h6C6C_6C6C, scl: 4'd7,  mir: 1'b0, en: 1'b1, pos: 47, n: 16, hold: 1, pat: 8'b01_10_11_00, bsy: 1'b1};

        // Reset state
        #2;
        check("rst_col", 0, int'(col), 0);
        check("rst_valid", 0, int'(col_valid), 0);
        check("rst_ready", 0, int'(row_ready), 1);
        check("rst_busy", 0, int'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a drawn line
        load_row(32'hE4E4_E4E4);
        start_line(4'd7, 1'b0, 20, 1'b1);
        for (int p = 0; p <= 25; p++) begin
            pix_x = POS_W'(p);
            if (p == 3) begin
                row_data  = 32'h5555_5555;
                row_valid = 1'b1;
            end
            tick();
            row_valid = 1'b0;
        end
        check("pre_rst_col", 25, int'(col), 2);
        check("pre_rst_ready", 25, int'(row_ready), 0);
        check("pre_rst_busy", 25, int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_col", 0, int'(col), 0);
        check("mid_rst_valid", 0, int'(col_valid), 0);
        check("mid_rst_ready", 0, int'(row_ready), 1);
        check("mid_rst_busy", 0, int'(busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Vector table: one full line sweep per record
        for (int v = 0; v < 7; v++) begin
            load_row(vecs[v].row);
            start_line(vecs[v].scl, vecs[v].mir, vecs[v].pos, vecs[v].en);
            sweep(-1, 32'h0);
            for (int p = 0; p < NPIX; p++) begin
                int e;
                e = 0;
                if (p >= vecs[v].pos && p < vecs[v].pos + vecs[v].n)
                    e = int'(vecs[v].pat[(3 - (((p - vecs[v].pos) / vecs[v].hold) % 4)) * 2 +: 2]);
                check($sformatf("vec%0d_pix", v), p, int'(cap[p]), (e != 0) ? (4 | e) : 0);
            end
            check($sformatf("vec%0d_busy", v), v, int'(busy), int'(vecs[v].bsy));
        end

        // Double buffering across three lines
        load_row(32'hE4E4_E4E4);
        start_line(4'd7, 1'b0, 20, 1'b1);
        check("buf_ready_l1", 0, int'(row_ready), 1);
        sweep(5, 32'h5555_5555);
        check("buf_l1_pix", 20, int'(cap[20]), 7);
        check("buf_l1_pix", 21, int'(cap[21]), 6);
        check("buf_l1_pix", 23, int'(cap[23]), 0);
        check("buf_ready_after_b", 0, int'(row_ready), 0);
        start_line(4'd7, 1'b0, 20, 1'b1);
        check("buf_ready_l2", 0, int'(row_ready), 1);
        sweep(-1, 32'h0);
        for (int p = 18; p < 38; p++)
            check("buf_l2_pix", p, int'(cap[p]), (p >= 20 && p < 36) ? 5 : 0);
        start_line(4'd7, 1'b0, 20, 1'b1);
        sweep(-1, 32'h0);
        begin
            int nv;
            nv = 0;
            for (int p = 0; p < NPIX; p++) nv += int'(cap[p][2]);
            check("buf_l3_valid_count", 0, nv, 0);
        end
        check("buf_l3_busy", 0, int'(busy), 0);

        // Row arriving in the same cycle as line_start with the shadow empty
        row_data  = 32'hAAAA_AAAA;
        row_valid = 1'b1;
        start_line(4'd7, 1'b0, 10, 1'b1);
        row_valid = 1'b0;
        check("direct_ready", 0, int'(row_ready), 1);
        sweep(-1, 32'h0);
        check("direct_pix", 10, int'(cap[10]), 6);
        check("direct_pix", 25, int'(cap[25]), 6);
        check("direct_pix", 26, int'(cap[26]), 0);

        // Fastest step (scale=0 -> 15/8 texel per pixel): texels 0,1,3,5,...,15
        load_row(32'hE4E4_E4E4);
        start_line(4'd0, 1'b0, 10, 1'b1);
        sweep(-1, 32'h0);
        begin
            int fexp [10] = '{3, 2, 0, 2, 0, 2, 0, 2, 0, 0};
            for (int k = 0; k < 10; k++)
                check("fast_pix", 10 + k, int'(cap[10 + k]), (fexp[k] != 0) ? (4 | fexp[k]) : 0);
        end

        // line_start while drawing texel 5 aborts the line
        load_row(32'hE4E4_E4E4);
        start_line(4'd7, 1'b0, 20, 1'b1);
        load_row(32'hE4E4_E4E4);
        for (int p = 0; p < 25; p++) begin
            pix_x = POS_W'(p);
            tick();
        end
        check("abort_pre_col", 24, int'(col), 3);
        pix_x      = POS_W'(25);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        check("abort_col", 0, int'({col_valid, col}), 0);
        check("abort_busy", 0, int'(busy), 1);
        pix_x = POS_W'(26);
        tick();
        check("abort_wait_col", 26, int'({col_valid, col}), 0);
        pix_x = POS_W'(20);
        tick();
        check("abort_new_texel0", 20, int'({col_valid, col}), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
